// File: rtl/worm_n.sv
// ---------------------------------------------------------------------------
// worm_n : rotary-encoder driven "worm" on an LED track.
//
// A quadrature encoder (ROT_A/ROT_B, asynchronous) is synchronised and
// filtered into detent events. Each detent moves the worm head one position
// up or down the track. The LED output lights the head plus a tail of
// min(Y, LED_W) LEDs in total.
//
// Configuration macro:
//   WORM_SATURATE_EN  undefined (default): head wraps at the track ends and
//                     the tail wraps around from index 0 to LED_W-1.
//                     defined: head clamps at 0 / LED_W-1 and the tail is
//                     truncated at index 0.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-high reset
//   ROT_A  in   encoder channel A (asynchronous)
//   ROT_B  in   encoder channel B (asynchronous)
//   Y      in   [LEN_W]  requested worm length in lit LEDs
//   LED    out  [LED_W]  registered LED pattern, LED[0] leftmost
//   head   out  [clog2(LED_W)]  registered worm head index
//   step   out  one-cycle pulse per decoded detent
//   dir    out  direction of last detent (1 = increment), held
// ---------------------------------------------------------------------------
module worm_n #(
  parameter int LED_W = 8,
  parameter int LEN_W = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ROT_A,
  input  logic                       ROT_B,
  input  logic [LEN_W-1:0]           Y,
  output logic [LED_W-1:0]           LED,
  output logic [$clog2(LED_W)-1:0]   head,
  output logic                       step,
  output logic                       dir
);

  localparam int              HW       = $clog2(LED_W);
  localparam logic [HW-1:0]   HEAD_MAX = HW'(LED_W - 1);

  logic             r_a_s1, r_a_s2;
  logic             r_b_s1, r_b_s2;
  logic [1:0]       r_warm;
  logic             r_armed;
  logic             r_q1, r_q2, r_q1_d;
  logic [HW-1:0]    r_head;
  logic             r_dir;
  logic [LED_W-1:0] r_led;

  logic             w_step;
  logic [31:0]      w_len;
  logic [31:0]      w_dist;
  logic [LED_W-1:0] w_led;

  // Detent = rising edge of the filtered q1 flop.
  assign w_step = r_q1 & ~r_q1_d;

  // Effective length clamped to the track, then each LED is lit when its
  // distance behind the head is shorter than that length.
  always_comb begin
    w_led  = '0;
    w_dist = '0;
    w_len  = (32'(Y) > 32'(LED_W)) ? 32'(LED_W) : 32'(Y);
    for (int i = 0; i < LED_W; i++) begin
      if (32'(r_head) >= 32'(i)) begin
        w_dist = 32'(r_head) - 32'(i);
      end else begin
`ifdef WORM_SATURATE_EN
        // Positions above the head are never part of a truncated tail.
        w_dist = 32'hFFFF_FFFF;
`else
        w_dist = 32'(r_head) + 32'(LED_W) - 32'(i);
`endif
      end
      w_led[i] = (w_dist < w_len);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_s1  <= 1'b0;
      r_a_s2  <= 1'b0;
      r_b_s1  <= 1'b0;
      r_b_s2  <= 1'b0;
      r_warm  <= 2'b00;
      r_armed <= 1'b0;
      r_q1    <= 1'b0;
      r_q2    <= 1'b0;
      r_q1_d  <= 1'b0;
      r_head  <= '0;
      r_dir   <= 1'b0;
      r_led   <= '0;
    end else begin
      r_a_s1 <= ROT_A;
      r_a_s2 <= r_a_s1;
      r_b_s1 <= ROT_B;
      r_b_s2 <= r_b_s1;

      // The synchroniser holds reset zeros for two clocks; only once it shows
      // real input levels, and the encoder is seen at rest (A=B=0), does the
      // filter start. This drops a detent that was cut by reset and stops
      // restored A=B=1 levels from looking like a fresh q1 rise.
      r_warm <= {r_warm[0], 1'b1};
      if (r_warm[1] && !r_a_s2 && !r_b_s2) begin
        r_armed <= 1'b1;
      end

      if (r_armed) begin
        if (r_a_s2 && r_b_s2) begin
          r_q1 <= 1'b1;
        end else if (!r_a_s2 && !r_b_s2) begin
          r_q1 <= 1'b0;
        end
        if (r_a_s2 && !r_b_s2) begin
          r_q2 <= 1'b1;
        end else if (!r_a_s2 && r_b_s2) begin
          r_q2 <= 1'b0;
        end
      end

      r_q1_d <= r_q1;

      if (w_step) begin
        r_dir <= r_q2;
        if (r_q2) begin
`ifdef WORM_SATURATE_EN
          if (r_head != HEAD_MAX) r_head <= r_head + HW'(1);
`else
          r_head <= (r_head == HEAD_MAX) ? '0 : r_head + HW'(1);
`endif
        end else begin
`ifdef WORM_SATURATE_EN
          if (r_head != '0) r_head <= r_head - HW'(1);
`else
          r_head <= (r_head == '0) ? HEAD_MAX : r_head - HW'(1);
`endif
        end
      end

      r_led <= w_led;
    end
  end

  assign LED  = r_led;
  assign head = r_head;
  assign step = w_step;
  assign dir  = r_dir;

endmodule

// File: tb/tb_worm_n.sv
// ---------------------------------------------------------------------------
// tb_worm_n : directed self-checking bench for worm_n (LED_W=8, LEN_W=4).
// Expected values are hand-derived; WORM_SATURATE_EN selects the clamping
// expectations where they differ from the wrapping ones.
// ---------------------------------------------------------------------------
module tb_worm_n;

  localparam int LED_W = 8;
  localparam int LEN_W = 4;
`ifdef WORM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             ROT_A;
  logic             ROT_B;
  logic [LEN_W-1:0] Y;
  logic [LED_W-1:0] LED;
  logic [2:0]       head;
  logic             step;
  logic             dir;

  int n_checks = 0;
  int n_fail   = 0;
  int step_cnt = 0;
  int base     = 0;

  worm_n #(.LED_W(LED_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .ROT_A (ROT_A),
    .ROT_B (ROT_B),
    .Y     (Y),
    .LED   (LED),
    .head  (head),
    .step  (step),
    .dir   (dir)
  );

  always #5 clk = ~clk;

  // step is sampled just before the edge that ends its cycle
  always @(posedge clk) begin
    if (step === 1'b1) step_cnt = step_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All stimulus tasks start and end on a falling edge.
  task automatic set_ab(input logic a, input logic b, input int hold);
    ROT_A = a;
    ROT_B = b;
    repeat (hold) @(negedge clk);
  endtask

  task automatic detent_inc(input int hold);
    set_ab(1'b1, 1'b0, hold);
    set_ab(1'b1, 1'b1, hold);
    set_ab(1'b0, 1'b1, hold);
    set_ab(1'b0, 1'b0, hold);
  endtask

  task automatic detent_dec(input int hold);
    set_ab(1'b0, 1'b1, hold);
    set_ab(1'b1, 1'b1, hold);
    set_ab(1'b1, 1'b0, hold);
    set_ab(1'b0, 1'b0, hold);
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    ROT_A = 1'b0;
    ROT_B = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    ROT_A = 1'b0;
    ROT_B = 1'b0;
    Y     = 4'd3;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_led",  32'(LED),  32'h0);
    chk("rst_head", 32'(head), 32'h0);
    chk("rst_step", 32'(step), 32'h0);
    chk("rst_dir",  32'(dir),  32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // one increment detent with latency checks
    set_ab(1'b1, 1'b0, 4);
    ROT_A = 1'b1;
    ROT_B = 1'b1;
    repeat (3) @(negedge clk);
    chk("lat_step_hi", 32'(step), 32'h1);
    chk("lat_head_old", 32'(head), 32'h0);
    @(negedge clk);
    chk("lat_step_lo", 32'(step), 32'h0);
    chk("lat_head_new", 32'(head), 32'h1);
    chk("lat_dir", 32'(dir), 32'h1);
    chk("lat_led_old", 32'(LED), SAT ? 32'h01 : 32'hC1);
    @(negedge clk);
    chk("lat_led_new", 32'(LED), SAT ? 32'h03 : 32'h83);
    set_ab(1'b0, 1'b1, 4);
    set_ab(1'b0, 1'b0, 4);
    chk("inc_steps", 32'(step_cnt), 32'd1);

    // decrement to 0, then below 0
    detent_dec(2);
    settle();
    chk("dec1_head", 32'(head), 32'h0);
    chk("dec1_dir", 32'(dir), 32'h0);
    detent_dec(2);
    settle();
    chk("dec2_head", 32'(head), SAT ? 32'h0 : 32'h7);
    chk("dec2_led", 32'(LED), SAT ? 32'h01 : 32'hE0);
    chk("dec2_steps", 32'(step_cnt), 32'd3);

    // chatter on A with B held low
    ROT_B = 1'b0;
    for (int k = 0; k < 10; k++) begin
      ROT_A = 1'b1;
      @(negedge clk);
      ROT_A = 1'b0;
      @(negedge clk);
    end
    settle();
    chk("chat_steps", 32'(step_cnt), 32'd3);
    chk("chat_head", 32'(head), SAT ? 32'h0 : 32'h7);

    // length changes at head=4
    do_reset();
    repeat (4) detent_inc(2);
    settle();
    chk("y3_head", 32'(head), 32'h4);
    chk("y3_led", 32'(LED), 32'h1C);
    Y = 4'd0;
    @(negedge clk);
    chk("y0_led", 32'(LED), 32'h00);
    chk("y0_head", 32'(head), 32'h4);
    Y = 4'd9;
    @(negedge clk);
    chk("y9_led", 32'(LED), SAT ? 32'h1F : 32'hFF);
    chk("y9_head", 32'(head), 32'h4);
    Y = 4'd0;
    detent_inc(2);
    settle();
    chk("y0_track_head", 32'(head), 32'h5);
    chk("y0_track_led", 32'(LED), 32'h00);

    // reset in the middle of a detent
    Y = 4'd3;
    set_ab(1'b1, 1'b0, 2);
    set_ab(1'b1, 1'b1, 4);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_head", 32'(head), 32'h0);
    chk("mid_rst_led", 32'(LED), 32'h0);
    chk("mid_rst_dir", 32'(dir), 32'h0);
    chk("mid_rst_step", 32'(step), 32'h0);
    @(negedge clk);
    @(negedge clk);
    base = step_cnt;
    reset = 1'b0;
    repeat (6) @(negedge clk);
    set_ab(1'b0, 1'b1, 4);
    set_ab(1'b0, 1'b0, 4);
    chk("mid_rst_nostep", 32'(step_cnt), 32'(base));
    detent_inc(2);
    settle();
    chk("post_rst_head", 32'(head), 32'h1);
    chk("post_rst_steps", 32'(step_cnt), 32'(base + 1));

    // 20 increments spaced 8 clocks apart
    do_reset();
    base = step_cnt;
    repeat (20) detent_inc(2);
    settle();
    chk("run20_steps", 32'(step_cnt), 32'(base + 20));
    chk("run20_head", 32'(head), SAT ? 32'h7 : 32'h4);
    chk("run20_led", 32'(LED), SAT ? 32'hE0 : 32'h1C);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
